// File: rtl/io_bus_controller_pkg.sv
// Shared address map, I/O window and register-select decode for io_bus_controller.
package io_bus_controller_pkg;

    localparam logic [3:0]  IO_WINDOW  = 4'hF;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned NUM_SW   = 10;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KEY,
        SEL_SW,
        SEL_KCTRL
    } io_sel_e;

    // Map a word-aligned byte address onto the register it selects.
    function automatic io_sel_e decode_sel(input logic [31:0] word_addr);
        case (word_addr)
            ADDR_HEX:   return SEL_HEX;
            ADDR_LEDR:  return SEL_LEDR;
            ADDR_LEDG:  return SEL_LEDG;
            ADDR_KEY:   return SEL_KEY;
            ADDR_SW:    return SEL_SW;
            ADDR_KCTRL: return SEL_KCTRL;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_controller_key_debouncer.sv
// Per-key debouncer: accepts a new synchronised level only after it has held
// for DEBOUNCE_CYCLES consecutive cycles; rise pulses for one cycle on 0->1.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BITS        = 18
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_sync,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [CNT_BITS-1:0] cnt;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (in_sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= in_sync;
                rise   <= in_sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/io_bus_controller.sv
// Memory-mapped I/O controller: HEX/LEDR/LEDG output registers, synchronised
// and debounced KEY inputs with sticky press flags, synchronised SW inputs.
module io_bus_controller
    import io_bus_controller_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BITS        = 18,
    parameter int HEX_BITS        = 24,
    parameter int LEDR_BITS       = 10,
    parameter int LEDG_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DBITS-1:0]     addr,
    input  logic                 wr_en,
    input  logic [DBITS-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [DBITS-1:0]     rd_data,
    output logic                 io_hit,
    input  logic [3:0]           key_raw,
    input  logic [9:0]           sw_raw,
    output logic [HEX_BITS-1:0]  hex_out,
    output logic [LEDR_BITS-1:0] ledr_out,
    output logic [LEDG_BITS-1:0] ledg_out,
    output logic                 key_event
);

    logic [NUM_KEYS-1:0] key_s1, key_s2;
    logic [NUM_SW-1:0]   sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] key_sync, key_stable, key_rise, sticky;
    logic [DBITS-1:0]    word_addr;
    io_sel_e             sel;
    logic                wr_fire;
    logic [NUM_KEYS-1:0] kctrl_clr;
    logic                unused_bits;

    assign io_hit    = (addr[DBITS-1 -: 4] == IO_WINDOW);
    assign word_addr = {addr[DBITS-1:2], 2'b00};
    assign sel       = decode_sel(32'(word_addr));
    assign wr_fire   = wr_en && io_hit;
    assign kctrl_clr = (wr_fire && sel == SEL_KCTRL) ? wr_data[NUM_KEYS-1:0] : '0;
    // Keys are active-low on the board; pressed=1 from here on.
    assign key_sync  = ~key_s2;

    assign unused_bits = ^{addr[1:0], wr_data[DBITS-1:HEX_BITS]};

    // Two-flop synchronisers; key flops reset to the released (high) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
        ) u_debouncer (
            .clk    (clk),
            .reset_n(reset_n),
            .in_sync(key_sync[i]),
            .stable (key_stable[i]),
            .rise   (key_rise[i])
        );
    end

    // Software-writable output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out  <= '0;
            ledr_out <= '0;
            ledg_out <= '0;
        end else if (wr_fire) begin
            case (sel)
                SEL_HEX:  hex_out  <= wr_data[HEX_BITS-1:0];
                SEL_LEDR: ledr_out <= wr_data[LEDR_BITS-1:0];
                SEL_LEDG: ledg_out <= wr_data[LEDG_BITS-1:0];
                default:  ;
            endcase
        end
    end

    // Sticky press flags (a rise beats a same-cycle clear) and the new-press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky    <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= |(key_rise & ~sticky);
            sticky    <= (sticky & ~kctrl_clr) | key_rise;
        end
    end

    // Combinational load data, zero-extended; reflects pre-write register state.
    always_comb begin
        rd_data = '0;
        if (rd_en && io_hit) begin
            case (sel)
                SEL_HEX:   rd_data = DBITS'(hex_out);
                SEL_LEDR:  rd_data = DBITS'(ledr_out);
                SEL_LEDG:  rd_data = DBITS'(ledg_out);
                SEL_KEY:   rd_data = DBITS'(key_stable);
                SEL_SW:    rd_data = DBITS'(sw_s2);
                SEL_KCTRL: rd_data = DBITS'(sticky);
                default:   rd_data = '0;
            endcase
        end
    end

endmodule
